// File: rtl/cpu_bus_arbiter.sv
// cpu_bus_arbiter: registered N-port arbiter onto a single-outstanding bus.
// A winner is chosen in IDLE (round-robin or fixed priority), its command is
// latched into the bus outputs, and the transaction stays ACTIVE until the bus
// reports ready or the optional timeout expires. Completion is reported to the
// granted port combinationally in the cycle the bus answers.
module cpu_bus_arbiter #(
  parameter int               PORTS          = 3,
  parameter int               ADDR_WIDTH     = 32,
  parameter int               DATA_WIDTH     = 32,
  parameter int               ROUND_ROBIN    = 1,
  parameter logic [PORTS-1:0] READ_ONLY_MASK = {PORTS{1'b0}},
  parameter int               TIMEOUT        = 0
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  output logic                          o_bus_rw,
  output logic                          o_bus_request,
  input  logic                          i_bus_ready,
  output logic [ADDR_WIDTH-1:0]         o_bus_address,
  input  logic [DATA_WIDTH-1:0]         i_bus_rdata,
  output logic [DATA_WIDTH-1:0]         o_bus_wdata,
  input  logic [PORTS-1:0]              i_port_request,
  input  logic [PORTS-1:0]              i_port_rw,
  input  logic [PORTS*ADDR_WIDTH-1:0]   i_port_address,
  input  logic [PORTS*DATA_WIDTH-1:0]   i_port_wdata,
  output logic [PORTS-1:0]              o_port_ready,
  output logic [PORTS-1:0]              o_port_error,
  output logic [DATA_WIDTH-1:0]         o_port_rdata,
  output logic                          o_grant_valid,
  output logic [$clog2(PORTS)-1:0]      o_grant
);

  localparam int              GW          = $clog2(PORTS);
  localparam int              CW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [GW-1:0]   LAST_INIT   = GW'(PORTS - 1);
  localparam logic [CW-1:0]   TIMEOUT_CNT = CW'(TIMEOUT);
  localparam logic            TIMEOUT_EN  = (TIMEOUT > 0) ? 1'b1 : 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [GW-1:0]          grant_r;
  logic [GW-1:0]          last_r;
  logic [CW-1:0]          cnt_r;
  logic                   bus_request_r;
  logic                   bus_rw_r;
  logic [ADDR_WIDTH-1:0]  bus_address_r;
  logic [DATA_WIDTH-1:0]  bus_wdata_r;

  logic [GW-1:0]          idx_s;
  logic                   hit_s;
  logic [GW-1:0]          win_s;
  logic                   win_found_s;
  logic                   load_s;
  logic                   done_s;
  logic                   timeout_s;
  logic [PORTS-1:0]       port_ready_s;
  logic [PORTS-1:0]       port_error_s;

  // Winner search: fixed order from port 0, or rotating order starting after the last winner.
  always_comb begin
    idx_s       = '0;
    hit_s       = 1'b0;
    win_s       = '0;
    win_found_s = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      idx_s       = (ROUND_ROBIN != 0) ? GW'((int'(last_r) + 1 + i) % PORTS) : GW'(i);
      hit_s       = ~win_found_s & i_port_request[idx_s];
      win_s       = hit_s ? idx_s : win_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state plus completion/timeout decode for the granted port.
  always_comb begin
    state_nxt_s  = state_r;
    load_s       = 1'b0;
    done_s       = 1'b0;
    timeout_s    = 1'b0;
    port_ready_s = '0;
    port_error_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nxt_s = ST_ACTIVE;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        timeout_s = TIMEOUT_EN & (cnt_r == TIMEOUT_CNT);
        if (i_bus_ready) begin
          // A port that dropped its request still lets the bus cycle finish, but sees no ready.
          port_ready_s[grant_r] = i_port_request[grant_r];
          done_s                = 1'b1;
          state_nxt_s           = ST_IDLE;
        end else if (timeout_s) begin
          port_ready_s[grant_r] = 1'b1;
          port_error_s[grant_r] = 1'b1;
          done_s                = 1'b1;
          state_nxt_s           = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Command latch, grant/last pointers and the stall counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bus_request_r <= 1'b0;
      bus_rw_r      <= 1'b0;
      bus_address_r <= '0;
      bus_wdata_r   <= '0;
      grant_r       <= '0;
      last_r        <= LAST_INIT;
      cnt_r         <= '0;
    end else if (load_s) begin
      bus_request_r <= 1'b1;
      bus_rw_r      <= i_port_rw[win_s] & ~READ_ONLY_MASK[win_s];
      bus_address_r <= i_port_address[win_s*ADDR_WIDTH +: ADDR_WIDTH];
      bus_wdata_r   <= i_port_wdata[win_s*DATA_WIDTH +: DATA_WIDTH];
      grant_r       <= win_s;
      cnt_r         <= '0;
    end else if (done_s) begin
      bus_request_r <= 1'b0;
      last_r        <= grant_r;
      cnt_r         <= '0;
    end else if ((state_r == ST_ACTIVE) && (cnt_r != TIMEOUT_CNT)) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // A reset cycle never reports a completion for the abandoned transaction.
  assign o_port_ready  = port_ready_s & ~{PORTS{i_reset}};
  assign o_port_error  = port_error_s & ~{PORTS{i_reset}};
  assign o_port_rdata  = i_bus_rdata;
  assign o_bus_request = bus_request_r;
  assign o_bus_rw      = bus_rw_r;
  assign o_bus_address = bus_address_r;
  assign o_bus_wdata   = bus_wdata_r;
  assign o_grant_valid = (state_r == ST_ACTIVE);
  assign o_grant       = grant_r;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: instance A (round-robin, port0 read-only,
// timeout 4) and instance B (fixed priority, no timeout) share port inputs.
module tb_cpu_bus_arbiter;
  localparam int P  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [P-1:0]    req;
  logic [P-1:0]    rw;
  logic [AW-1:0]   addr_v  [P];
  logic [DW-1:0]   wdata_v [P];
  logic [P*AW-1:0] port_address;
  logic [P*DW-1:0] port_wdata;
  assign port_address = {addr_v[2], addr_v[1], addr_v[0]};
  assign port_wdata   = {wdata_v[2], wdata_v[1], wdata_v[0]};

  logic bus_ready_a, bus_ready_b;
  logic [DW-1:0] rdata_a, rdata_b;

  logic          rw_a, breq_a, gv_a;
  logic [AW-1:0] baddr_a;
  logic [DW-1:0] bwdata_a, prdata_a;
  logic [P-1:0]  prdy_a, perr_a;
  logic [1:0]    grant_a;

  logic          rw_b, breq_b, gv_b;
  logic [AW-1:0] baddr_b;
  logic [DW-1:0] bwdata_b, prdata_b;
  logic [P-1:0]  prdy_b, perr_b;
  logic [1:0]    grant_b;

  cpu_bus_arbiter #(.PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1),
                    .READ_ONLY_MASK(3'b001), .TIMEOUT(4)) dut_a (
    .i_clock(clk), .i_reset(rst), .o_bus_rw(rw_a), .o_bus_request(breq_a),
    .i_bus_ready(bus_ready_a), .o_bus_address(baddr_a), .i_bus_rdata(rdata_a),
    .o_bus_wdata(bwdata_a), .i_port_request(req), .i_port_rw(rw),
    .i_port_address(port_address), .i_port_wdata(port_wdata),
    .o_port_ready(prdy_a), .o_port_error(perr_a), .o_port_rdata(prdata_a),
    .o_grant_valid(gv_a), .o_grant(grant_a));

  cpu_bus_arbiter #(.PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0),
                    .READ_ONLY_MASK(3'b000), .TIMEOUT(0)) dut_b (
    .i_clock(clk), .i_reset(rst), .o_bus_rw(rw_b), .o_bus_request(breq_b),
    .i_bus_ready(bus_ready_b), .o_bus_address(baddr_b), .i_bus_rdata(rdata_b),
    .o_bus_wdata(bwdata_b), .i_port_request(req), .i_port_rw(rw),
    .i_port_address(port_address), .i_port_wdata(port_wdata),
    .o_port_ready(prdy_b), .o_port_error(perr_b), .o_port_rdata(prdata_b),
    .o_grant_valid(gv_b), .o_grant(grant_b));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req = 3'b000; rw = 3'b000;
    bus_ready_a = 1'b0; bus_ready_b = 1'b0;
    rdata_a = 32'h0; rdata_b = 32'h0;
    for (int p = 0; p < P; p++) begin
      addr_v[p] = 32'h0; wdata_v[p] = 32'h0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [31:0] a0;
    logic [31:0] a2;
    logic [31:0] w2;
    logic        bready;
    logic [31:0] rdata;
    logic        e_breq;
    logic [31:0] e_addr;
    logic        e_rw;
    logic [31:0] e_wdata;
    logic [2:0]  e_ready;
    logic [1:0]  e_grant;
  } vec_t;

  vec_t vecs [9];

  // behavioural model state for the randomized run
  bit          m_busy;
  int          m_g, m_last, m_waits;
  logic [31:0] m_addr, m_wdata;
  logic        m_rw;
  logic [2:0]  e_ready, e_err, prev_ready;
  int          gq_a [$];
  int          gq_b [$];
  int          exp_rr [5];
  bit          found;
  int          pp;

  initial begin
    // {req, rw, a0, a2, w2, bready, rdata, e_breq, e_addr, e_rw, e_wdata, e_ready, e_grant}
    vecs[0] = '{3'b001, 3'b000, 32'h1000, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,        3'b000, 2'd0};
    vecs[1] = '{3'b001, 3'b000, 32'h1000, 32'h0,  32'h0,        1'b0, 32'h0,        1'b1, 32'h1000, 1'b0, 32'h0,        3'b000, 2'd0};
    vecs[2] = '{3'b001, 3'b000, 32'h1000, 32'h0,  32'h0,        1'b1, 32'hDEADBEEF, 1'b1, 32'h1000, 1'b0, 32'h0,        3'b001, 2'd0};
    vecs[3] = '{3'b000, 3'b000, 32'h1000, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,        3'b000, 2'd0};
    vecs[4] = '{3'b101, 3'b101, 32'h20,   32'h40, 32'h12345678, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,        3'b000, 2'd0};
    vecs[5] = '{3'b101, 3'b101, 32'h20,   32'h40, 32'h12345678, 1'b1, 32'h0,        1'b1, 32'h40,   1'b1, 32'h12345678, 3'b100, 2'd2};
    vecs[6] = '{3'b001, 3'b001, 32'h20,   32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,        3'b000, 2'd0};
    vecs[7] = '{3'b001, 3'b001, 32'h20,   32'h0,  32'h0,        1'b1, 32'hCAFEF00D, 1'b1, 32'h20,   1'b0, 32'h0,        3'b001, 2'd0};
    vecs[8] = '{3'b000, 3'b000, 32'h0,    32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 32'h0,        3'b000, 2'd0};

    // ---- reset state, with requests and bus ready active during reset
    rst = 1'b1;
    clear_inputs();
    req = 3'b111; bus_ready_a = 1'b1; bus_ready_b = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst breq_a", 64'(breq_a), 64'(0));
    chk("rst gv_a", 64'(gv_a), 64'(0));
    chk("rst grant_a", 64'(grant_a), 64'(0));
    chk("rst addr_a", 64'(baddr_a), 64'(0));
    chk("rst wdata_a", 64'(bwdata_a), 64'(0));
    chk("rst rw_a", 64'(rw_a), 64'(0));
    chk("rst ready_a", 64'(prdy_a), 64'(0));
    chk("rst breq_b", 64'(breq_b), 64'(0));

    // ---- table-driven: basic read, read-only forcing, port2 write
    do_reset();
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      req = vecs[v].req; rw = vecs[v].rw;
      addr_v[0] = vecs[v].a0; addr_v[2] = vecs[v].a2; wdata_v[2] = vecs[v].w2;
      bus_ready_a = vecs[v].bready; rdata_a = vecs[v].rdata;
      #1;
      chk($sformatf("vec%0d breq", v), 64'(breq_a), 64'(vecs[v].e_breq));
      chk($sformatf("vec%0d gv", v), 64'(gv_a), 64'(vecs[v].e_breq));
      chk($sformatf("vec%0d ready", v), 64'(prdy_a), 64'(vecs[v].e_ready));
      chk($sformatf("vec%0d err", v), 64'(perr_a), 64'(0));
      if (vecs[v].e_breq) begin
        chk($sformatf("vec%0d addr", v), 64'(baddr_a), 64'(vecs[v].e_addr));
        chk($sformatf("vec%0d rw", v), 64'(rw_a), 64'(vecs[v].e_rw));
        chk($sformatf("vec%0d grant", v), 64'(grant_a), 64'(vecs[v].e_grant));
        if (vecs[v].e_rw) chk($sformatf("vec%0d wdata", v), 64'(bwdata_a), 64'(vecs[v].e_wdata));
      end
      if (vecs[v].e_ready != 3'b000) chk($sformatf("vec%0d rdata", v), 64'(prdata_a), 64'(vecs[v].rdata));
    end

    // ---- all ports held requesting, bus answers in the first ACTIVE cycle
    do_reset();
    req = 3'b111;
    addr_v[0] = 32'hA0; addr_v[1] = 32'hA1; addr_v[2] = 32'hA2;
    wdata_v[0] = 32'hD0;
    prev_ready = 3'b000;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      bus_ready_a = breq_a; bus_ready_b = breq_b;
      rdata_b = 32'h7700 + 32'(c);
      #1;
      if (prev_ready != 3'b000) chk($sformatf("rr idle gap c%0d", c), 64'(breq_a), 64'(0));
      prev_ready = prdy_a;
      for (int p = 0; p < P; p++) begin
        if (prdy_a[p]) gq_a.push_back(p);
        if (prdy_b[p]) gq_b.push_back(p);
      end
      if (prdy_b != 3'b000) begin
        chk($sformatf("fp addr c%0d", c), 64'(baddr_b), 64'(32'hA0));
        chk($sformatf("fp wdata c%0d", c), 64'(bwdata_b), 64'(32'hD0));
        chk($sformatf("fp rw c%0d", c), 64'(rw_b), 64'(0));
        chk($sformatf("fp rdata c%0d", c), 64'(prdata_b), 64'(rdata_b));
      end
      chk($sformatf("fp err c%0d", c), 64'(perr_b), 64'(0));
    end
    exp_rr = '{0, 1, 2, 0, 1};
    chk("rr grant count", 64'(gq_a.size() >= 5), 64'(1));
    chk("fp grant count", 64'(gq_b.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++) begin
      if (gq_a.size() > i) chk($sformatf("rr order %0d", i), 64'(gq_a[i]), 64'(exp_rr[i]));
      if (gq_b.size() > i) chk($sformatf("fp order %0d", i), 64'(gq_b[i]), 64'(0));
    end

    // ---- timeout on port1, port2 pending behind it
    do_reset();
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      addr_v[1] = 32'h300; addr_v[2] = 32'h400;
      req = (n == 0) ? 3'b010 : ((n < 6) ? 3'b110 : 3'b100);
      bus_ready_a = (n == 8);
      #1;
      chk($sformatf("to errb n%0d", n), 64'(perr_b), 64'(0));
      if (n == 0 || n == 6) chk($sformatf("to breq n%0d", n), 64'(breq_a), 64'(0));
      if (n >= 1 && n <= 4) begin
        chk($sformatf("to stall breq n%0d", n), 64'(breq_a), 64'(1));
        chk($sformatf("to stall grant n%0d", n), 64'(grant_a), 64'(1));
        chk($sformatf("to stall ready n%0d", n), 64'({perr_a, prdy_a}), 64'(0));
      end
      if (n == 5) chk("to expire", 64'({breq_a, perr_a, prdy_a}), 64'({1'b1, 3'b010, 3'b010}));
      if (n == 6) chk("to after ready", 64'({perr_a, prdy_a}), 64'(0));
      if (n == 7) chk("to next grant", 64'({breq_a, grant_a}), 64'({1'b1, 2'd2}));
      if (n == 8) chk("to port2 done", 64'({perr_a, prdy_a}), 64'({3'b000, 3'b100}));
    end

    // ---- address held while ACTIVE; ready exactly at the timeout count wins
    do_reset();
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      req = (n < 6) ? 3'b001 : 3'b000;
      addr_v[0] = (n == 0) ? 32'h100 : 32'h200;
      bus_ready_a = (n == 5); rdata_a = 32'h55AA;
      #1;
      if (n >= 1 && n <= 5) chk($sformatf("hold addr n%0d", n), 64'(baddr_a), 64'(32'h100));
      if (n >= 1 && n <= 4) chk($sformatf("hold ready n%0d", n), 64'(prdy_a), 64'(0));
      if (n == 5) chk("edge ready", 64'({perr_a, prdy_a, prdata_a}), 64'({3'b000, 3'b001, 32'h55AA}));
    end

    // ---- reset while port1 is ACTIVE (last winner was port0)
    @(negedge clk); req = 3'b010; bus_ready_a = 1'b0; #1;
    @(negedge clk); #1;
    chk("rstact grant", 64'({breq_a, grant_a}), 64'({1'b1, 2'd1}));
    @(negedge clk); rst = 1'b1; #1;
    chk("rstact ready", 64'(prdy_a), 64'(0));
    @(negedge clk); rst = 1'b0; req = 3'b111; #1;
    chk("rstact breq", 64'({breq_a, gv_a, prdy_a, perr_a}), 64'(0));
    @(negedge clk); bus_ready_a = 1'b1; #1;
    chk("rstact first grant", 64'({breq_a, grant_a}), 64'({1'b1, 2'd0}));
    chk("rstact ready0", 64'(prdy_a), 64'(3'b001));

    // ---- randomized run against the transaction-level model
    do_reset();
    m_busy = 1'b0; m_last = P - 1; m_waits = 0; m_g = 0;
    m_addr = 32'h0; m_wdata = 32'h0; m_rw = 1'b0;
    prev_ready = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int p = 0; p < P; p++) begin
        if (req[p] && prev_ready[p] && ($urandom_range(0, 1) == 0)) begin
          req[p] = 1'b0;
        end else if ((req[p] && prev_ready[p]) || (!req[p] && $urandom_range(0, 2) == 0)) begin
          req[p] = 1'b1; rw[p] = 1'($urandom_range(0, 1));
          addr_v[p] = $urandom; wdata_v[p] = $urandom;
        end else if (req[p] && $urandom_range(0, 7) == 0) begin
          addr_v[p] = $urandom;
        end
      end
      bus_ready_a = ($urandom_range(0, 3) == 0);
      rdata_a = $urandom;
      #1;
      e_ready = 3'b000; e_err = 3'b000;
      if (m_busy) begin
        if (bus_ready_a) e_ready[m_g] = req[m_g];
        else if (m_waits == 4) begin e_ready[m_g] = 1'b1; e_err[m_g] = 1'b1; end
      end
      chk($sformatf("rnd breq c%0d", c), 64'(breq_a), 64'(m_busy));
      chk($sformatf("rnd gv c%0d", c), 64'(gv_a), 64'(m_busy));
      chk($sformatf("rnd ready c%0d", c), 64'(prdy_a), 64'(e_ready));
      chk($sformatf("rnd err c%0d", c), 64'(perr_a), 64'(e_err));
      if (m_busy) begin
        chk($sformatf("rnd cmd c%0d", c), 64'({grant_a, rw_a, baddr_a}), 64'({2'(m_g), m_rw, m_addr}));
        if (m_rw) chk($sformatf("rnd wdata c%0d", c), 64'(bwdata_a), 64'(m_wdata));
      end
      if (e_ready != 3'b000 && e_err == 3'b000) chk($sformatf("rnd rdata c%0d", c), 64'(prdata_a), 64'(rdata_a));
      prev_ready = e_ready;
      // advance the model across the coming clock edge
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= P; k++) begin
          pp = (m_last + k) % P;
          if (!found && req[pp]) begin
            found = 1'b1; m_busy = 1'b1; m_g = pp; m_waits = 0;
            m_addr = addr_v[pp]; m_wdata = wdata_v[pp];
            m_rw = rw[pp] & (pp != 0);
          end
        end
      end else if (bus_ready_a || m_waits == 4) begin
        m_busy = 1'b0; m_last = m_g;
      end else begin
        m_waits++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
Registered N-port bus arbiter. Connects PORTS requesters (instruction fetch, load/store, DMA, debug) to one single-outstanding memory bus.
Grants by round-robin or fixed priority and latches the winner's command into registered bus outputs. Supports per-port read-only forcing and an optional bus timeout that completes a stalled transaction with an error flag.
Sits between CPU-side ports and the system bus/interconnect.

Parameters:
PORTS, 3, number of requester ports (2..8).
ADDR_WIDTH, 32, address width.
DATA_WIDTH, 32, data width.
ROUND_ROBIN, 1, 1 = round-robin; 0 = fixed priority (lowest index wins).
READ_ONLY_MASK, 0, bit p set forces port p's transactions to read (rw=0).
TIMEOUT, 0, cycles an ACTIVE transaction may wait for i_bus_ready; 0 disables.

Ports:
i_clock  in  1  clock; all logic on rising edge.
i_reset  in  1  synchronous active-high reset.
o_bus_rw  out  1  1 = write.
o_bus_request  out  1  bus request, registered.
i_bus_ready  in  1  bus transaction complete.
o_bus_address  out  ADDR_WIDTH  registered address.
i_bus_rdata  in  DATA_WIDTH  read data, valid with i_bus_ready.
o_bus_wdata  out  DATA_WIDTH  registered write data.
i_port_request  in  PORTS  per-port request, held until ready.
i_port_rw  in  PORTS  per-port rw.
i_port_address  in  PORTS*ADDR_WIDTH  port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
i_port_wdata  in  PORTS*DATA_WIDTH  port p at [p*DATA_WIDTH +: DATA_WIDTH].
o_port_ready  out  PORTS  one-hot completion pulse.
o_port_error  out  PORTS  timeout flag, only alongside o_port_ready.
o_port_rdata  out  DATA_WIDTH  = i_bus_rdata, shared by all ports.
o_grant_valid  out  1  high in ACTIVE.
o_grant  out  $clog2(PORTS)  granted port index.

Behaviour:
- Reset (synchronous): state IDLE, all registered outputs 0, grant 0, timeout counter 0, RR pointer last = PORTS-1 so port 0 is searched first.
- Reset mid-ACTIVE: transaction abandoned. o_bus_request is 0 the next cycle; no ready or error pulse.
- IDLE: o_bus_request=0 and i_bus_ready is ignored. If any request is sampled, select winner g:
  - Fixed priority: lowest set index.
  - Round-robin: first set index searching last+1, last+2, ... with wrap-around modulo PORTS.
- On selecting g: latch o_bus_address=addr[g], o_bus_wdata=wdata[g], o_bus_rw=rw[g] & ~READ_ONLY_MASK[g]. Set o_bus_request=1, grant=g, counter=0, go to ACTIVE.
- Latency: request sampled at edge k gives bus request visible after edge k (1 cycle).
- ACTIVE: bus outputs held stable. Port input changes are not propagated.
- Completion (combinational): o_port_ready[g] = i_bus_ready & i_port_request[g]. On that edge: o_bus_request=0, last=g, go to IDLE.
- Minimum one IDLE cycle between transactions. Back-to-back requests from the same port are allowed.
- Port dropping its request while granted is a protocol violation. The bus transaction still runs to completion with ready masked; no data loss to other ports.
- Timeout (TIMEOUT>0): counter increments each ACTIVE cycle without i_bus_ready (saturates). When counter==TIMEOUT and i_bus_ready=0:
  - o_port_ready[g]=1 and o_port_error[g]=1 for that cycle (requester held); o_port_rdata is undefined.
  - Drop o_bus_request, go to IDLE, last=g.
  - If i_bus_ready=1 in that same cycle, it is a normal completion with no error.
- o_port_error is never asserted when TIMEOUT=0.
- Non-granted ports never see ready.

Test Plan:
- PORTS=3, port0 read 0x1000, bus ready 2 cycles after request with rdata 0xDEADBEEF -> o_bus_request high one cycle after request with address 0x1000, rw=0; o_port_ready[0]=1 in the ready cycle with rdata 0xDEADBEEF; bus request low next cycle.
- ROUND_ROBIN=1, all three ports held requesting, bus ready after 1 cycle -> grant order 0,1,2,0,1 with one IDLE cycle between each. Same stimulus with ROUND_ROBIN=0 -> grant 0 every time.
- READ_ONLY_MASK=3'b001, port0 rw=1 address 0x20, port2 write 0x40 wdata 0x12345678 -> port0 bus rw=0; port2 bus rw=1 with wdata 0x12345678.
- TIMEOUT=4, port1 request with no i_bus_ready -> after 4 stalled ACTIVE cycles o_port_ready[1]=o_port_error[1]=1 for one cycle, bus request drops, a pending port2 request is then granted.
- Port0 address changed 0x100 -> 0x200 while ACTIVE -> o_bus_address stays 0x100 until ready.
- Reset asserted during ACTIVE -> o_bus_request=0 next cycle, no ready pulse; after release with all ports requesting and ROUND_ROBIN=1 -> port 0 granted first.
